// File: rtl/risc_pkg.sv
// Shared definitions for the RISC instruction word layout, used by both the
// instruction-register field decoder and the encoder/loader on the write side.
package risc_pkg;

  localparam int INSTR_W  = 32;

  localparam int OP_MSB   = 31;
  localparam int OP_W     = 5;
  localparam int SRC_MSB  = 26;
  localparam int SRC_W    = 5;
  localparam int DEST_MSB = 21;
  localparam int DEST_W   = 5;
  localparam int IMM_MSB  = 16;
  localparam int IMM_W    = 14;
  localparam int TYPE_MSB = 2;
  localparam int TYPE_W   = 2;
  localparam int HALT_BIT = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  // Places each field at its fixed bit position; no sign extension or checks.
  function automatic logic [INSTR_W-1:0] pack_instr(
    input logic [OP_W-1:0]   op,
    input logic [SRC_W-1:0]  src,
    input logic [DEST_W-1:0] dest,
    input logic [IMM_W-1:0]  imm,
    input logic [TYPE_W-1:0] typ,
    input logic              halt
  );
    logic [INSTR_W-1:0] w;
    w = '0;
    w[OP_MSB -: OP_W]     = op;
    w[SRC_MSB -: SRC_W]   = src;
    w[DEST_MSB -: DEST_W] = dest;
    w[IMM_MSB -: IMM_W]   = imm;
    w[TYPE_MSB -: TYPE_W] = typ;
    w[HALT_BIT]           = halt;
    return w;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with an occupancy counter. Flush empties it in one
// cycle and takes priority over a same-cycle push or pop.
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   used;
  logic          do_push;
  logic          do_pop;

  assign full    = (used == (PW+1)'(DEPTH));
  assign empty   = (used == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap naturally as DEPTH is a power of 2.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      used   <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      used <= used + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
  end

  // Storage array; contents need no reset because occupancy gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// Packs decoded instruction fields into 32-bit words, buffers them, and
// streams them into instruction memory at consecutive addresses until the
// halt word is written or the address space runs out.
module instr_encoder_loader
  import risc_pkg::*;
#(
  parameter int AW        = 8,
  parameter int BASE_ADDR = 0,
  parameter int DEPTH     = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [4:0]         Operation,
  input  logic [4:0]         Src_1,
  input  logic [4:0]         Dest,
  input  logic [13:0]        immediate,
  input  logic [1:0]         instr_type,
  input  logic               halt_bit,
  output logic               mem_we,
  output logic [AW-1:0]      mem_addr,
  output logic [31:0]        mem_wdata,
  input  logic               mem_ready,
  output logic [AW:0]        count,
  output logic               load_done,
  output logic               overflow
);

  localparam logic [AW-1:0] BASE      = AW'(BASE_ADDR);
  localparam logic [AW-1:0] ADDR_MAX  = '1;
  localparam logic [AW:0]   COUNT_MAX = {1'b1, {AW{1'b0}}};

  state_t             state;
  logic [AW-1:0]      addr;
  logic [AW:0]        count_q;
  logic               overflow_q;
  logic               halt_seen;

  logic [INSTR_W-1:0] packed_word;
  logic [INSTR_W-1:0] head;
  logic               fifo_full;
  logic               fifo_empty;
  logic               push;
  logic               write_done;
  logic               head_halt;
  logic               ovf_hit;

  assign packed_word = pack_instr(Operation, Src_1, Dest, immediate, instr_type, halt_bit);

  assign in_ready   = (state == LOAD) && !fifo_full && !halt_seen;
  assign push       = in_valid && in_ready;
  assign mem_we     = (state == LOAD) && !fifo_empty;
  assign write_done = mem_we && mem_ready;
  assign head_halt  = head[HALT_BIT];
  assign ovf_hit    = write_done && !head_halt && (addr == ADDR_MAX);

  assign mem_addr   = addr;
  assign mem_wdata  = mem_we ? head : '0;
  assign count      = count_q;
  assign overflow   = overflow_q;
  assign load_done  = (state == DONE);

  sync_fifo #(
    .DEPTH (DEPTH),
    .W     (INSTR_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (ovf_hit),
    .push  (push),
    .pop   (write_done),
    .wdata (packed_word),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Session FSM: start opens a session, halt write or address exhaustion closes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      addr       <= BASE;
      count_q    <= '0;
      overflow_q <= 1'b0;
      halt_seen  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state      <= LOAD;
            addr       <= BASE;
            count_q    <= '0;
            overflow_q <= 1'b0;
            halt_seen  <= 1'b0;
          end
        end
        LOAD: begin
          if (push && halt_bit) halt_seen <= 1'b1;
          if (write_done) begin
            if (count_q != COUNT_MAX) count_q <= count_q + 1'b1;
            if (addr != ADDR_MAX) addr <= addr + 1'b1;
            if (head_halt) begin
              state <= DONE;
            end else if (addr == ADDR_MAX) begin
              overflow_q <= 1'b1;
              state      <= DONE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench: one loader with an 8-bit address space for the functional
// scenarios and one with a 2-bit address space for exhaustion and restart.
module tb_instr_encoder_loader;

  logic        clk;
  logic        rst;
  logic        start_a, start_b;
  logic        valid_a, valid_b;
  logic [4:0]  op, src, dest;
  logic [13:0] imm;
  logic [1:0]  typ;
  logic        halt;
  logic        mem_ready;

  logic        in_ready_a, mem_we_a, load_done_a, overflow_a;
  logic [7:0]  mem_addr_a;
  logic [31:0] mem_wdata_a;
  logic [8:0]  count_a;

  logic        in_ready_b, mem_we_b, load_done_b, overflow_b;
  logic [1:0]  mem_addr_b;
  logic [31:0] mem_wdata_b;
  logic [2:0]  count_b;

  int compared   = 0;
  int mismatched = 0;

  // Words for bundles whose only non-zero field is Operation = k+1.
  logic [31:0] op_words [5] = '{32'h08000000, 32'h10000000, 32'h18000000,
                                32'h20000000, 32'h28000000};

  instr_encoder_loader #(.AW(8), .BASE_ADDR(0), .DEPTH(4)) u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .in_valid(valid_a), .in_ready(in_ready_a),
    .Operation(op), .Src_1(src), .Dest(dest), .immediate(imm), .instr_type(typ),
    .halt_bit(halt), .mem_we(mem_we_a), .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a),
    .mem_ready(mem_ready), .count(count_a), .load_done(load_done_a), .overflow(overflow_a)
  );

  instr_encoder_loader #(.AW(2), .BASE_ADDR(0), .DEPTH(4)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .in_valid(valid_b), .in_ready(in_ready_b),
    .Operation(op), .Src_1(src), .Dest(dest), .immediate(imm), .instr_type(typ),
    .halt_bit(halt), .mem_we(mem_we_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
    .mem_ready(mem_ready), .count(count_b), .load_done(load_done_b), .overflow(overflow_b)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Backstop so a stuck run still ends with a visible report.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input logic [4:0] o, input logic [4:0] s, input logic [4:0] d,
                               input logic [13:0] i, input logic [1:0] t, input logic h);
    op = o; src = s; dest = d; imm = i; typ = t; halt = h;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic nextCycle();
    @(negedge clk);
  endtask

  task automatic resetDut();
    rst = 1'b1;
    nextCycle();
    nextCycle();
    rst = 1'b0;
  endtask

  // Directed scenarios; inputs change and outputs are sampled on falling edges.
  initial begin
    rst = 1'b1; start_a = 0; start_b = 0; valid_a = 0; valid_b = 0; mem_ready = 0;
    applyStimulus(0, 0, 0, 0, 0, 0);

    // Reset values
    nextCycle();
    checkOutput("rst_in_ready",  32'(in_ready_a),  0);
    checkOutput("rst_mem_we",    32'(mem_we_a),    0);
    checkOutput("rst_mem_addr",  32'(mem_addr_a),  0);
    checkOutput("rst_mem_wdata", mem_wdata_a,      0);
    checkOutput("rst_load_done", 32'(load_done_a), 0);
    checkOutput("rst_overflow",  32'(overflow_a),  0);
    checkOutput("rst_count",     32'(count_a),     0);
    nextCycle();
    rst = 1'b0;

    // Single word
    start_a = 1; nextCycle(); start_a = 0;
    checkOutput("single_ready", 32'(in_ready_a), 1);
    mem_ready = 1;
    applyStimulus(5'd3, 5'd2, 5'd3, 14'h10, 2'd1, 1'b0);
    valid_a = 1; nextCycle(); valid_a = 0;
    checkOutput("single_we",    32'(mem_we_a),   1);
    checkOutput("single_addr",  32'(mem_addr_a), 0);
    checkOutput("single_wdata", mem_wdata_a,     32'h18860082);
    nextCycle();
    checkOutput("single_count", 32'(count_a),    1);
    checkOutput("single_we_off", 32'(mem_we_a),  0);

    // Halt termination
    resetDut();
    start_a = 1; nextCycle(); start_a = 0;
    mem_ready = 1;
    applyStimulus(5'd1, 0, 0, 0, 0, 0);
    valid_a = 1; nextCycle();
    applyStimulus(0, 5'd31, 0, 14'h3FFF, 2'd3, 0);
    checkOutput("halt_w0_addr", 32'(mem_addr_a), 0);
    checkOutput("halt_w0_data", mem_wdata_a, 32'h08000000);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("halt_w1_addr", 32'(mem_addr_a), 1);
    checkOutput("halt_w1_data", mem_wdata_a, 32'h07C1FFFE);
    nextCycle();
    valid_a = 0;
    checkOutput("halt_w2_addr",  32'(mem_addr_a), 2);
    checkOutput("halt_w2_data",  mem_wdata_a, 32'h00000001);
    checkOutput("halt_refuse",   32'(in_ready_a), 0);
    nextCycle();
    checkOutput("halt_done",     32'(load_done_a), 1);
    checkOutput("halt_ready",    32'(in_ready_a),  0);
    checkOutput("halt_count",    32'(count_a),     3);
    checkOutput("halt_we_off",   32'(mem_we_a),    0);

    // Backpressure
    resetDut();
    start_a = 1; nextCycle(); start_a = 0;
    mem_ready = 0;
    for (int k = 0; k < 4; k++) begin
      applyStimulus(5'(k + 1), 0, 0, 0, 0, 0);
      valid_a = 1;
      checkOutput($sformatf("bp_ready_%0d", k), 32'(in_ready_a), 1);
      nextCycle();
    end
    applyStimulus(5'd5, 0, 0, 0, 0, 0);
    checkOutput("bp_full",      32'(in_ready_a), 0);
    checkOutput("bp_we",        32'(mem_we_a),   1);
    checkOutput("bp_addr",      32'(mem_addr_a), 0);
    checkOutput("bp_data",      mem_wdata_a,     op_words[0]);
    nextCycle();
    checkOutput("bp_we_hold",   32'(mem_we_a),   1);
    checkOutput("bp_addr_hold", 32'(mem_addr_a), 0);
    checkOutput("bp_data_hold", mem_wdata_a,     op_words[0]);
    mem_ready = 1;
    nextCycle();
    checkOutput("bp_ready_again", 32'(in_ready_a), 1);
    for (int k = 1; k < 5; k++) begin
      checkOutput($sformatf("bp_addr_%0d", k), 32'(mem_addr_a), 32'(k));
      checkOutput($sformatf("bp_data_%0d", k), mem_wdata_a, op_words[k]);
      nextCycle();
      valid_a = 0;
    end
    checkOutput("bp_drained", 32'(mem_we_a), 0);
    checkOutput("bp_count",   32'(count_a),  5);

    // Address space exhaustion on the 2-bit instance
    resetDut();
    start_b = 1; nextCycle(); start_b = 0;
    mem_ready = 1;
    for (int k = 0; k < 5; k++) begin
      applyStimulus(5'(k + 1), 0, 0, 0, 0, 0);
      valid_b = 1;
      checkOutput($sformatf("ovf_ready_%0d", k), 32'(in_ready_b), 1);
      if (k >= 1) begin
        checkOutput($sformatf("ovf_addr_%0d", k - 1), 32'(mem_addr_b), 32'(k - 1));
        checkOutput($sformatf("ovf_data_%0d", k - 1), mem_wdata_b, op_words[k - 1]);
      end
      nextCycle();
    end
    valid_b = 0;
    checkOutput("ovf_flag",   32'(overflow_b),  1);
    checkOutput("ovf_done",   32'(load_done_b), 1);
    checkOutput("ovf_we_off", 32'(mem_we_b),    0);
    checkOutput("ovf_count",  32'(count_b),     4);
    checkOutput("ovf_ready",  32'(in_ready_b),  0);
    nextCycle();
    checkOutput("ovf_no_fifth", 32'(mem_we_b),   0);
    checkOutput("ovf_no_wrap",  32'(mem_addr_b), 3);

    // Restart from DONE on the 2-bit instance
    start_b = 1; nextCycle(); start_b = 0;
    checkOutput("rs_overflow", 32'(overflow_b),  0);
    checkOutput("rs_count",    32'(count_b),     0);
    checkOutput("rs_done",     32'(load_done_b), 0);
    checkOutput("rs_ready",    32'(in_ready_b),  1);
    checkOutput("rs_addr",     32'(mem_addr_b),  0);
    applyStimulus(5'd5, 0, 0, 0, 0, 1);
    valid_b = 1; nextCycle(); valid_b = 0;
    checkOutput("rs_we",    32'(mem_we_b),   1);
    checkOutput("rs_waddr", 32'(mem_addr_b), 0);
    checkOutput("rs_wdata", mem_wdata_b,     32'h28000001);
    nextCycle();
    checkOutput("rs_done2",  32'(load_done_b), 1);
    checkOutput("rs_count2", 32'(count_b),     1);

    // Reset in the middle of a session
    resetDut();
    start_a = 1; nextCycle(); start_a = 0;
    mem_ready = 0;
    for (int k = 0; k < 3; k++) begin
      applyStimulus(5'(k + 1), 0, 0, 0, 0, 0);
      valid_a = 1;
      nextCycle();
    end
    valid_a = 0;
    mem_ready = 1;
    nextCycle();
    mem_ready = 0;
    checkOutput("mid_count_pre", 32'(count_a),    1);
    checkOutput("mid_addr_pre",  32'(mem_addr_a), 1);
    rst = 1; mem_ready = 1;
    nextCycle();
    checkOutput("mid_we",    32'(mem_we_a),   0);
    checkOutput("mid_ready", 32'(in_ready_a), 0);
    checkOutput("mid_count", 32'(count_a),    0);
    checkOutput("mid_addr",  32'(mem_addr_a), 0);
    rst = 0;
    nextCycle();
    checkOutput("mid_idle_we", 32'(mem_we_a), 0);
    start_a = 1; nextCycle(); start_a = 0;
    checkOutput("mid_discarded", 32'(mem_we_a),   0);
    checkOutput("mid_ready2",    32'(in_ready_a), 1);
    applyStimulus(5'd5, 0, 0, 0, 0, 0);
    valid_a = 1; nextCycle(); valid_a = 0;
    checkOutput("mid_new_we",   32'(mem_we_a),   1);
    checkOutput("mid_new_addr", 32'(mem_addr_a), 0);
    checkOutput("mid_new_data", mem_wdata_a,     op_words[4]);
    nextCycle();
    checkOutput("mid_new_count", 32'(count_a), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
